// File: rtl/mcu_read_responder.sv
// mcu_read_responder
// Responder end of the MCU read interface used by the MMU table walker.
// It accepts a level-held read request, waits LATENCY cycles, then returns
// zero-extended little-endian byte/halfword/word data from a byte-addressed
// backing store with a one-cycle valid pulse. A host write port preloads the
// store, and it may write in any state.
//
// Parameters:
//   ADDR_W  - byte address width; the store holds 2**ADDR_W bytes
//   LATENCY - cycles from request acceptance to out_valid (1..15)
//
// Ports:
//   in_clk, in_rst_n          - clock (rising edge), async active-low reset
//   in_ren, in_addr, in_size  - read request (size 00 byte, 01 half, 10 word)
//   out_data, out_valid       - read data, qualified by the one-cycle pulse
//   out_err                   - reserved size or (optionally) misalignment
//   out_busy                  - a request is in flight
//   in_wr_en, in_wr_addr,
//   in_wr_data, in_wr_be      - host word write with byte enables
//
// Build option:
//   MCU_ALIGN_CHECK_EN - when defined, misaligned halfword/word reads
//                        return out_err=1 and out_data=0; otherwise the
//                        address is aligned down and the read succeeds.
module mcu_read_responder #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 3
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_ren,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    output logic [31:0]       out_data,
    output logic              out_valid,
    output logic              out_err,
    output logic              out_busy,
    input  logic              in_wr_en,
    input  logic [ADDR_W-3:0] in_wr_addr,
    input  logic [31:0]       in_wr_data,
    input  logic [3:0]        in_wr_be
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              last_v_q, last_v_d;
    logic              ren_prev_q;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [31:0]       mem_q [DEPTH];

    logic              new_req_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       rd_byte_sh_s;
    logic [31:0]       rd_half_sh_s;
    logic              misalign_s;
    logic              rd_err_s;
    logic [31:0]       rd_data_s;

    // Backing store host write port; contents survive reset by design.
    always_ff @(posedge in_clk) begin
        if (in_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (in_wr_be[i]) begin
                    mem_q[in_wr_addr][8*i +: 8] <= in_wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read data path from the latched request; halfword/word are aligned down.
    always_comb begin
        rd_word_s    = mem_q[addr_q[ADDR_W-1:2]];
        rd_byte_sh_s = rd_word_s >> {addr_q[1:0], 3'b000};
        rd_half_sh_s = rd_word_s >> {addr_q[1], 4'b0000};
`ifdef MCU_ALIGN_CHECK_EN
        misalign_s = ((size_q == 2'b01) && addr_q[0]) ||
                     ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        rd_err_s = (size_q == 2'b11) || misalign_s;
        if (rd_err_s) begin
            rd_data_s = 32'h0000_0000;
        end else begin
            case (size_q)
                2'b00:   rd_data_s = {24'h00_0000, rd_byte_sh_s[7:0]};
                2'b01:   rd_data_s = {16'h0000, rd_half_sh_s[15:0]};
                2'b10:   rd_data_s = rd_word_s;
                default: rd_data_s = 32'h0000_0000;
            endcase
        end
    end

    // A held ren only re-triggers when the request differs from the last one served.
    always_comb begin
        new_req_s = in_ren && (!ren_prev_q || !last_v_q ||
                               (in_addr != addr_q) || (in_size != size_q));
    end

    // Next-state and output logic; RESP may accept directly for back-to-back reads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        last_v_d = last_v_q;
        data_d   = data_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (new_req_s) begin
                    state_d  = ST_WAIT;
                    cnt_d    = 4'(LATENCY - 1);
                    addr_d   = in_addr;
                    size_d   = in_size;
                    last_v_d = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    data_d  = rd_data_s;
                    err_d   = rd_err_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, request record and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            size_q     <= 2'b00;
            last_v_q   <= 1'b0;
            ren_prev_q <= 1'b0;
            data_q     <= 32'h0000_0000;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            last_v_q   <= last_v_d;
            ren_prev_q <= in_ren;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_err   = err_q;
    assign out_busy  = busy_q;

endmodule

// File: tb/tb_mcu_read_responder.sv
// Directed testbench for mcu_read_responder with a cycle-count based
// reference model (byte array + acceptance/response edge numbers).
module tb_mcu_read_responder;

    localparam int AW  = 14;
    localparam int LAT = 3;

    logic          in_clk = 1'b0;
    logic          in_rst_n;
    logic          in_ren;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_size;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_err;
    logic          out_busy;
    logic          in_wr_en;
    logic [AW-3:0] in_wr_addr;
    logic [31:0]   in_wr_data;
    logic [3:0]    in_wr_be;

    mcu_read_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_ren    (in_ren),
        .in_addr   (in_addr),
        .in_size   (in_size),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_err   (out_err),
        .out_busy  (out_busy),
        .in_wr_en  (in_wr_en),
        .in_wr_addr(in_wr_addr),
        .in_wr_data(in_wr_data),
        .in_wr_be  (in_wr_be)
    );

    always #5 in_clk = ~in_clk;

    int n_vec = 0;
    int n_err = 0;
    int valid_seen = 0;

    // reference model state
    logic [7:0]    mem_m [0:(2**AW)-1];
    int            cyc = 0;
    int            m_free_at = 0;
    int            m_resp_at = -1;
    logic          m_ren_prev = 1'b0;
    logic          m_last_v = 1'b0;
    logic [AW-1:0] m_last_addr = '0;
    logic [1:0]    m_last_size = 2'b00;
    logic [31:0]   exp_data = 32'h0;
    logic          exp_err = 1'b0;
    logic          exp_valid = 1'b0;
    logic          exp_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_read(input int a, input logic [1:0] sz,
                              output logic [31:0] d, output logic e);
        int ah;
        int aw;
        d = 32'h0;
        e = 1'b0;
        ah = a - (a % 2);
        aw = a - (a % 4);
        if (sz == 2'b11) begin
            e = 1'b1;
        end else begin
`ifdef MCU_ALIGN_CHECK_EN
            if ((sz == 2'b01 && ah != a) || (sz == 2'b10 && aw != a)) e = 1'b1;
`endif
            if (!e) begin
                case (sz)
                    2'b00:   d = {24'h0, mem_m[a]};
                    2'b01:   d = {16'h0, mem_m[ah+1], mem_m[ah]};
                    default: d = {mem_m[aw+3], mem_m[aw+2], mem_m[aw+1], mem_m[aw]};
                endcase
            end
        end
    endtask

    // Advance the model by one edge, clock the DUT, then compare all outputs.
    task automatic step();
        logic accept;
        cyc++;
        if (!in_rst_n) begin
            m_free_at  = 0;
            m_resp_at  = -1;
            m_ren_prev = 1'b0;
            m_last_v   = 1'b0;
            exp_data   = 32'h0;
            exp_err    = 1'b0;
            exp_valid  = 1'b0;
            exp_busy   = 1'b0;
        end else begin
            accept = in_ren && (cyc >= m_free_at) &&
                     (!m_ren_prev || !m_last_v || in_addr != m_last_addr || in_size != m_last_size);
            exp_valid = (cyc == m_resp_at);
            if (exp_valid) model_read(int'(m_last_addr), m_last_size, exp_data, exp_err);
            if (accept) begin
                m_last_addr = in_addr;
                m_last_size = in_size;
                m_last_v    = 1'b1;
                m_resp_at   = cyc + LAT;
                m_free_at   = cyc + LAT + 1;
            end
            exp_busy   = (cyc < m_free_at);
            m_ren_prev = in_ren;
        end
        if (in_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (in_wr_be[i]) mem_m[int'(in_wr_addr)*4 + i] = in_wr_data[8*i +: 8];
        end
        @(posedge in_clk);
        #1;
        chk("valid", {31'h0, out_valid}, {31'h0, exp_valid});
        chk("busy",  {31'h0, out_busy},  {31'h0, exp_busy});
        chk("err",   {31'h0, out_err},   {31'h0, exp_err});
        chk("data",  out_data, exp_data);
        if (out_valid) valid_seen++;
    endtask

    task automatic host_write(input int waddr, input logic [31:0] wd, input logic [3:0] be);
        in_wr_en   = 1'b1;
        in_wr_addr = waddr[AW-3:0];
        in_wr_data = wd;
        in_wr_be   = be;
        step();
        in_wr_en   = 1'b0;
        in_wr_be   = 4'b0000;
    endtask

    // One request pulse, then LAT+1 edges; pins latency, pulse count and literal data.
    task automatic read_req(input string name, input int a, input logic [1:0] sz,
                            input logic [31:0] lit_d, input logic lit_e);
        int first;
        int cnt;
        logic [31:0] got_d;
        logic got_e;
        first = -1;
        cnt   = 0;
        got_d = 32'h0;
        got_e = 1'b0;
        in_ren  = 1'b1;
        in_addr = a[AW-1:0];
        in_size = sz;
        step();
        chk({name, "_busy_at_accept"}, {31'h0, out_busy}, 32'h1);
        in_ren = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            if (out_valid) begin
                cnt++;
                if (first < 0) begin
                    first = i;
                    got_d = out_data;
                    got_e = out_err;
                end
            end
        end
        chk({name, "_latency"}, 32'(first), 32'(LAT));
        chk({name, "_pulses"}, 32'(cnt), 32'd1);
        chk({name, "_data_lit"}, got_d, lit_d);
        chk({name, "_err_lit"}, {31'h0, got_e}, {31'h0, lit_e});
        chk({name, "_busy_end"}, {31'h0, out_busy}, 32'h0);
    endtask

    initial begin
        int v0;
        for (int i = 0; i < 2**AW; i++) mem_m[i] = 8'h00;
        in_rst_n   = 1'b0;
        in_ren     = 1'b0;
        in_addr    = '0;
        in_size    = 2'b00;
        in_wr_en   = 1'b0;
        in_wr_addr = '0;
        in_wr_data = 32'h0;
        in_wr_be   = 4'b0000;

        // reset state
        repeat (3) step();
        chk("rst_data", out_data, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        in_rst_n = 1'b1;
        step();

        // preload
        host_write(0, 32'hDEAD_BEEF, 4'b1111);
        host_write(1, 32'h1234_5678, 4'b1111);

        // basic reads
        read_req("word0", 0, 2'b10, 32'hDEAD_BEEF, 1'b0);
        read_req("byte2", 2, 2'b00, 32'h0000_00AD, 1'b0);
        read_req("half2", 2, 2'b01, 32'h0000_DEAD, 1'b0);
        read_req("byte7", 7, 2'b00, 32'h0000_0012, 1'b0);

        // held ren at one address: exactly one response
        in_ren  = 1'b1;
        in_addr = 14'h0000;
        in_size = 2'b10;
        v0 = valid_seen;
        repeat (12) step();
        chk("hold_one_pulse", 32'(valid_seen - v0), 32'd1);
        // address change with ren still high: second response
        in_addr = 14'h0004;
        v0 = valid_seen;
        repeat (LAT + 2) step();
        chk("hold_second_pulse", 32'(valid_seen - v0), 32'd1);
        chk("hold_second_data", out_data, 32'h1234_5678);
        in_ren = 1'b0;
        step();

        // back-to-back: address change in WAIT is ignored, then accepted at k+LAT+1
        in_ren  = 1'b1;
        in_addr = 14'h0000;
        in_size = 2'b10;
        step();
        in_addr = 14'h0004;
        repeat (LAT) step();
        chk("b2b_first_valid", {31'h0, out_valid}, 32'h1);
        chk("b2b_first_data", out_data, 32'hDEAD_BEEF);
        step();
        chk("b2b_busy_kept", {31'h0, out_busy}, 32'h1);
        repeat (LAT) step();
        chk("b2b_second_valid", {31'h0, out_valid}, 32'h1);
        chk("b2b_second_data", out_data, 32'h1234_5678);
        in_ren = 1'b0;
        repeat (2) step();

        // reserved size and misaligned word
        read_req("size11", 0, 2'b11, 32'h0, 1'b1);
`ifdef MCU_ALIGN_CHECK_EN
        read_req("mis_word1", 1, 2'b10, 32'h0, 1'b1);
        read_req("mis_half3", 3, 2'b01, 32'h0, 1'b1);
`else
        read_req("mis_word1", 1, 2'b10, 32'hDEAD_BEEF, 1'b0);
        read_req("mis_half3", 3, 2'b01, 32'h0000_DEAD, 1'b0);
`endif

        // reset two cycles after acceptance
        in_ren  = 1'b1;
        in_addr = 14'h0000;
        in_size = 2'b10;
        step();
        in_ren = 1'b0;
        repeat (2) step();
        #2;
        in_rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'h0, out_busy}, 32'h0);
        chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("async_rst_data", out_data, 32'h0);
        v0 = valid_seen;
        repeat (2) step();
        in_rst_n = 1'b1;
        repeat (6) step();
        chk("rst_no_pulse", 32'(valid_seen - v0), 32'd0);
        read_req("after_rst", 0, 2'b10, 32'hDEAD_BEEF, 1'b0);

        // host write on the array-read edge is not seen by that read
        in_ren  = 1'b1;
        in_addr = 14'h0000;
        in_size = 2'b10;
        step();
        in_ren = 1'b0;
        repeat (LAT - 1) step();
        in_wr_en   = 1'b1;
        in_wr_addr = '0;
        in_wr_data = 32'h1122_3344;
        in_wr_be   = 4'b0001;
        step();
        in_wr_en = 1'b0;
        in_wr_be = 4'b0000;
        chk("wr_same_edge_valid", {31'h0, out_valid}, 32'h1);
        chk("wr_same_edge_old", out_data, 32'hDEAD_BEEF);
        step();
        read_req("wr_new", 0, 2'b10, 32'hDEAD_BE44, 1'b0);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mcu_read_responder.md
# mcu_read_responder

Responder end of the MCU read interface used by the MMU table walker. It samples a level-held read request (`ren`/`addr`/`size`), waits a fixed number of cycles, then returns byte/halfword/word data from a byte-addressed backing store with a one-cycle valid pulse. A host write port preloads the backing store, which holds page tables and test images.

## Interface
Parameters:
- `ADDR_W`, 14: byte address width; backing store holds 2**ADDR_W bytes.
- `LATENCY`, 3: cycles from request acceptance to `out_valid`. Legal range 1..15.

Ports:
- `in_clk`  input  1: clock. Everything is on the rising edge.
- `in_rst_n`  input  1: reset, asynchronous, active-low.
- `in_ren`  input  1: read request, level-held by the requester.
- `in_addr`  input  ADDR_W: byte address of the read.
- `in_size`  input  2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `out_data`  output  32: read data, little-endian, zero-extended.
- `out_valid`  output  1: one-cycle pulse; `out_data` and `out_err` are valid with it.
- `out_err`  output  1: error flag, qualified by `out_valid`.
- `out_busy`  output  1: a request is in flight.
- `in_wr_en`  input  1: host write strobe.
- `in_wr_addr`  input  ADDR_W-2: word address for the host write.
- `in_wr_data`  input  32: host write data.
- `in_wr_be`  input  4: byte enables; bit i writes `in_wr_data[8i+7:8i]`.

## Operation
- States and transitions:
  - IDLE → WAIT when `in_ren`=1 and the request is *new*. On that edge, latch addr/size and load the counter with LATENCY-1.
  - WAIT counts down. When the count is 0, go to RESP and read the array on that same edge.
  - RESP drives `out_valid`=1 for one cycle, then goes to IDLE.
- A request is *new* if either condition holds:
  - `in_ren` was 0 on the previous edge, or
  - {addr,size} differs from the last request served.
- This rule means a requester that holds `ren` high gets exactly one response per distinct {addr,size}. The table walker keeps `ren` high across stages and only changes the address, and this rule serves it correctly.
- Changes to `in_ren`, `in_addr` or `in_size` while in WAIT/RESP are ignored; the latched request completes.
- Read data:
  - byte: `{24'b0, mem[a]}`
  - halfword: `{16'b0, mem[a+1], mem[a]}`
  - word: `{mem[a+3]..mem[a]}`
- Size 11: `out_err`=1 and `out_data`=0.
- `out_data` and `out_err` hold their values from RESP until the next RESP. They are not cleared in IDLE.
- Host writes are accepted in any state. They update the bytes enabled by `in_wr_be` at the edge where `in_wr_en`=1.
- A host write on the same edge as the array read is not visible to that read; the read returns the old data.
- Reset clears state to IDLE, zeroes the counter, and clears the "last served" record. Memory contents are not cleared.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_err`=0, `out_busy`=0.
- If a request is accepted at edge k, `out_valid` is high from edge k+LATENCY to edge k+LATENCY+1.
- `out_busy` is high from edge k to edge k+LATENCY+1.
- Earliest next acceptance is edge k+LATENCY+1, which gives a throughput of one read per LATENCY+1 cycles.
- Reset asserted mid-request: outputs clear immediately (asynchronously) and no `out_valid` is produced.
- After reset deassertion, a held `in_ren` counts as new on the first edge.

## Configuration
- `MCU_ALIGN_CHECK_EN` defined:
  - A halfword with addr[0]≠0, or a word with addr[1:0]≠0, returns `out_err`=1 and `out_data`=0.
  - Timing is unchanged.
- Macro undefined:
  - Misaligned addresses are aligned down (halfword clears bit 0, word clears bits 1:0) and the read returns data with `out_err`=0.
  - Size 11 still errors.

## Test plan
- Preload word 0 = 0xDEADBEEF; request a word read at addr 0x0000 at edge k, LATENCY=3 → `out_valid` at k+3 only, `out_data`=0xDEADBEEF, `out_err`=0, `out_busy` high from k to k+4.
- From the same preload, read a byte at 0x0002 → 0x000000AD; read a halfword at 0x0002 → 0x0000DEAD.
- Hold `ren` high with the address at 0x0000 for 12 cycles → exactly one `out_valid`. Then change the address to 0x0004 while `ren` stays high → a second response with the word at 0x0004.
- Request size 11 → `out_err`=1, `out_data`=0. Request a word at 0x0001:
  - with `MCU_ALIGN_CHECK_EN`: `out_err`=1.
  - without it: 0xDEADBEEF, `out_err`=0.
- Assert `in_rst_n`=0 two cycles after acceptance → `out_busy`=0 and `out_valid` never pulses. Memory still reads 0xDEADBEEF after reset.
- Host write to word 0 with data 0x11223344 and `be`=0001 on the read edge → the read returns the old value 0xDEADBEEF; the next read returns 0xDEADBE44.
